// File: rtl/mac_receive.sv
// -----------------------------------------------------------------------------
// mac_receive
//   GMII receive MAC for the 1000M UDP path (counterpart of the transmit MAC).
//   Strips preamble/SFD, filters on destination MAC, captures the Ethernet
//   header, streams payload bytes (FCS excluded) into the downstream RX FIFO
//   and checks CRC32. One status pulse per accepted frame lets the downstream
//   side commit or discard what was written (store-and-forward).
//
// Ports
//   gmii_clk        in   GMII RX clock (125 MHz), all logic on rising edge
//   rst_n           in   asynchronous active-low reset
//   gmii_rx_dv      in   receive data valid
//   gmii_rx_er      in   receive error
//   gmii_rx_data    in   [7:0] receive byte
//   local_mac       in   [47:0] own MAC, [47:40] is first on the wire
//   promisc         in   1 = accept any destination
//   fifo_full       in   RX FIFO full
//   fifo_wrreq      out  payload write strobe
//   fifo_wrdata     out  [7:0] payload byte
//   rx_des_mac      out  [47:0] captured destination MAC
//   rx_src_mac      out  [47:0] captured source MAC
//   rx_type_length  out  [15:0] captured type/length
//   rx_pyd_length   out  [10:0] payload bytes actually written this frame
//   rx_done         out  one-cycle pulse at the end of every accepted frame
//   rx_err          out  valid with rx_done: 1 = discard the frame
//
// FIFO interface: fifo_wrreq is a one-cycle strobe; a byte is offered only
// when fifo_full is low in the cycle the write is decided. There is no
// back-pressure toward the wire, so a suppressed byte is lost and the frame
// is marked bad.
// -----------------------------------------------------------------------------
module mac_receive #(
  parameter int MAX_PYD = 1500,
  parameter int MIN_PRE = 1
) (
  input  logic        gmii_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rx_data,
  input  logic [47:0] local_mac,
  input  logic        promisc,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_wrdata,
  output logic [47:0] rx_des_mac,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_type_length,
  output logic [10:0] rx_pyd_length,
  output logic        rx_done,
  output logic        rx_err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_HEADER   = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_DROP     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [10:0] MAX_PYD_C   = 11'(MAX_PYD);
  localparam logic [2:0]  MIN_PRE_C   = 3'(MIN_PRE);
  localparam logic [7:0]  BYTE_PRE    = 8'h55;
  localparam logic [7:0]  BYTE_SFD    = 8'hD5;

  // Reflected CRC32, one byte, LSB first.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] r;
    r = crc;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ data[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else                r = r >> 1;
    end
    return r;
  endfunction

  // Registered GMII inputs; every decision below looks only at these.
  logic        rx_dv_q;
  logic        rx_er_q;
  logic [7:0]  rx_data_q;

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] dline_q, dline_d;   // payload delay line, oldest byte in [31:24]
  logic [2:0]  fill_q, fill_d;     // bytes held in the delay line (0..4)
  logic [10:0] pyd_cnt_q, pyd_cnt_d;
  logic        err_f_q, err_f_d;
  logic        er_seen_q, er_seen_d;
  logic [47:0] des_q, des_d;
  logic [47:0] src_q, src_d;
  logic [15:0] type_q, type_d;
  logic        wrreq_q, wrreq_d;
  logic [7:0]  wrdata_q, wrdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        dest_ok;

  assign dest_ok = (des_q == local_mac) || (&des_q) || promisc;

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    hdr_cnt_d = hdr_cnt_q;
    crc_d     = crc_q;
    dline_d   = dline_q;
    fill_d    = fill_q;
    pyd_cnt_d = pyd_cnt_q;
    err_f_d   = err_f_q;
    er_seen_d = er_seen_q;
    des_d     = des_q;
    src_d     = src_q;
    type_d    = type_q;
    wrreq_d   = 1'b0;
    wrdata_d  = wrdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_dv_q) begin
          if (rx_data_q == BYTE_PRE) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (!rx_dv_q) begin
          state_d = S_DROP;
        end else if (rx_data_q == BYTE_PRE) begin
          if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
        end else if (rx_data_q == BYTE_SFD && pre_cnt_q >= MIN_PRE_C) begin
          // SFD: start a fresh frame context.
          state_d   = S_HEADER;
          hdr_cnt_d = 4'd0;
          crc_d     = CRC_INIT;
          dline_d   = '0;
          fill_d    = 3'd0;
          pyd_cnt_d = '0;
          err_f_d   = 1'b0;
          er_seen_d = 1'b0;
          des_d     = '0;
          src_d     = '0;
          type_d    = '0;
        end else begin
          state_d = S_DROP;
        end
      end

      S_HEADER: begin
        if (!rx_dv_q) begin
          // Runt: report it so downstream discards anything partial.
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          crc_d = crc32_step(crc_q, rx_data_q);
          if (hdr_cnt_q < 4'd6)       des_d  = {des_q[39:0], rx_data_q};
          else if (hdr_cnt_q < 4'd12) src_d  = {src_q[39:0], rx_data_q};
          else                        type_d = {type_q[7:0], rx_data_q};
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          // des_q is complete once byte 6 is on the input.
          if (hdr_cnt_q == 4'd6 && !dest_ok) state_d = S_DROP;
          else if (hdr_cnt_q == 4'd13)       state_d = S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        if (!rx_dv_q) begin
          // Whatever is still in the delay line is the FCS; it is dropped.
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = err_f_q || er_seen_q || rx_er_q ||
                    (crc_q != CRC_RESIDUE) || (fill_q != 3'd4);
        end else begin
          crc_d   = crc32_step(crc_q, rx_data_q);
          dline_d = {dline_q[23:0], rx_data_q};
          if (fill_q == 3'd4) begin
            if (fifo_full || pyd_cnt_q >= MAX_PYD_C) begin
              err_f_d = 1'b1;
            end else begin
              wrreq_d   = 1'b1;
              wrdata_d  = dline_q[31:24];
              pyd_cnt_d = pyd_cnt_q + 11'd1;
            end
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
      end

      S_DROP: begin
        if (!rx_dv_q) state_d = S_IDLE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Receive errors anywhere inside a frame poison it.
    if (rx_er_q && (state_q == S_PREAMBLE || state_q == S_HEADER ||
                    state_q == S_PAYLOAD)) begin
      er_seen_d = 1'b1;
    end
  end

  always_ff @(posedge gmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_dv_q   <= 1'b0;
      rx_er_q   <= 1'b0;
      rx_data_q <= '0;
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      hdr_cnt_q <= '0;
      crc_q     <= CRC_INIT;
      dline_q   <= '0;
      fill_q    <= '0;
      pyd_cnt_q <= '0;
      err_f_q   <= 1'b0;
      er_seen_q <= 1'b0;
      des_q     <= '0;
      src_q     <= '0;
      type_q    <= '0;
      wrreq_q   <= 1'b0;
      wrdata_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rx_dv_q   <= gmii_rx_dv;
      rx_er_q   <= gmii_rx_er;
      rx_data_q <= gmii_rx_data;
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      hdr_cnt_q <= hdr_cnt_d;
      crc_q     <= crc_d;
      dline_q   <= dline_d;
      fill_q    <= fill_d;
      pyd_cnt_q <= pyd_cnt_d;
      err_f_q   <= err_f_d;
      er_seen_q <= er_seen_d;
      des_q     <= des_d;
      src_q     <= src_d;
      type_q    <= type_d;
      wrreq_q   <= wrreq_d;
      wrdata_q  <= wrdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign fifo_wrreq     = wrreq_q;
  assign fifo_wrdata    = wrdata_q;
  assign rx_des_mac     = des_q;
  assign rx_src_mac     = src_q;
  assign rx_type_length = type_q;
  assign rx_pyd_length  = pyd_cnt_q;
  assign rx_done        = done_q;
  assign rx_err         = err_q;

endmodule
